// File: rtl/vld_flow_ctrl.sv
// rtl/vld_flow_ctrl.sv - VLD enable sequencer with backpressure/MB-boundary stalls and statistics
//
// Purpose: drives vld_en (advances getbits and the VLD together) from bitstream
// availability and downstream FIFO backpressure. Holds at macroblock boundaries while
// motion compensation is busy. Keeps per-slice macroblock, slice and stall statistics.
//
// Ports:
//   clk, rst (sync, active-high), clk_en (0 freezes everything)
//   getbits_valid, rld_wr_almost_full, mvec_wr_almost_full, motcomp_busy  - flow inputs
//   macroblock_end, slice_end  - VLD pulses, honoured only in RUN
//   vld_en        - registered enable
//   state         - 0 IDLE, 1 RUN, 2 BP_STALL, 3 MB_WAIT
//   mb_cnt        - macroblocks completed in current slice
//   slice_cnt     - slices completed since reset (wraps)
//   stall_cycles  - cycles spent in BP_STALL or MB_WAIT (saturates)
module vld_flow_ctrl #(
  parameter int RESUME_DLY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             getbits_valid,
  input  logic             rld_wr_almost_full,
  input  logic             mvec_wr_almost_full,
  input  logic             motcomp_busy,
  input  logic             macroblock_end,
  input  logic             slice_end,
  output logic             vld_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] mb_cnt,
  output logic [CNT_W-1:0] slice_cnt,
  output logic [CNT_W-1:0] stall_cycles
);

  // hold_cnt only needs to count 0..RESUME_DLY-1
  localparam int HOLD_W = (RESUME_DLY > 1) ? $clog2(RESUME_DLY) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESUME_DLY - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_BP_STALL = 2'd2,
    S_MB_WAIT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               bp;
  logic               in_run;
  logic               in_stall;

  assign bp       = rld_wr_almost_full | mvec_wr_almost_full;
  assign in_run   = (state_q == S_RUN);
  assign in_stall = (state_q == S_BP_STALL) || (state_q == S_MB_WAIT);
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (getbits_valid && !bp) state_d = S_RUN;
      end
      S_RUN: begin
        if (bp) begin
          state_d = S_BP_STALL;
          hold_d  = '0;
        end else if (macroblock_end && motcomp_busy) begin
          state_d = S_MB_WAIT;
        end else if (!getbits_valid) begin
          state_d = S_IDLE;
        end
      end
      S_BP_STALL: begin
        // Any backpressure restarts the resume window.
        if (bp) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = getbits_valid ? S_RUN : S_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_MB_WAIT: begin
        if (!motcomp_busy) begin
          if (bp) begin
            state_d = S_BP_STALL;
            hold_d  = '0;
          end else begin
            state_d = getbits_valid ? S_RUN : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      vld_en       <= 1'b0;
      mb_cnt       <= '0;
      slice_cnt    <= '0;
      stall_cycles <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      hold_q  <= hold_d;
      // Looks ahead at next state so the enable lands one cycle after the input change.
      vld_en  <= (state_d == S_RUN) && getbits_valid && !bp;

      if (in_run && slice_end) begin
        mb_cnt <= '0;
      end else if (in_run && macroblock_end) begin
        mb_cnt <= mb_cnt + CNT_W'(1);
      end

      if (in_run && slice_end) begin
        slice_cnt <= slice_cnt + CNT_W'(1);
      end

      if (in_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vld_flow_ctrl.sv
// tb/tb_vld_flow_ctrl.sv - randomized self-checking bench for vld_flow_ctrl against a behavioural model
module tb_vld_flow_ctrl;

  localparam int RESUME_DLY = 2;
  localparam int CNT_W      = 4;
  localparam int CNT_MOD    = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst, clk_en, getbits_valid, rld_wr_almost_full, mvec_wr_almost_full;
  logic motcomp_busy, macroblock_end, slice_end;
  logic             vld_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] mb_cnt, slice_cnt, stall_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: state as plain ints, 0 IDLE 1 RUN 2 BP_STALL 3 MB_WAIT.
  int m_state, m_hold, m_vld, m_mb, m_slice, m_stall;

  vld_flow_ctrl #(.RESUME_DLY(RESUME_DLY), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .clk_en              (clk_en),
    .getbits_valid       (getbits_valid),
    .rld_wr_almost_full  (rld_wr_almost_full),
    .mvec_wr_almost_full (mvec_wr_almost_full),
    .motcomp_busy        (motcomp_busy),
    .macroblock_end      (macroblock_end),
    .slice_end           (slice_end),
    .vld_en              (vld_en),
    .state               (state),
    .mb_cnt              (mb_cnt),
    .slice_cnt           (slice_cnt),
    .stall_cycles        (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int bp, gv, ns, nh;
    if (rst) begin
      m_state = 0; m_hold = 0; m_vld = 0; m_mb = 0; m_slice = 0; m_stall = 0;
      return;
    end
    if (!clk_en) return;
    bp = (rld_wr_almost_full || mvec_wr_almost_full) ? 1 : 0;
    gv = getbits_valid ? 1 : 0;
    ns = m_state;
    nh = m_hold;
    if (m_state == 0) begin
      if (gv && !bp) ns = 1;
    end else if (m_state == 1) begin
      if (bp) begin ns = 2; nh = 0; end
      else if (macroblock_end && motcomp_busy) ns = 3;
      else if (!gv) ns = 0;
    end else if (m_state == 2) begin
      if (bp) nh = 0;
      else if (m_hold == RESUME_DLY - 1) ns = gv ? 1 : 0;
      else nh = m_hold + 1;
    end else begin
      if (!motcomp_busy) begin
        if (bp) begin ns = 2; nh = 0; end
        else ns = gv ? 1 : 0;
      end
    end
    if (m_state == 1) begin
      if (slice_end) begin
        m_mb = 0;
        m_slice = (m_slice + 1) % CNT_MOD;
      end else if (macroblock_end) begin
        m_mb = (m_mb + 1) % CNT_MOD;
      end
    end
    if ((m_state == 2 || m_state == 3) && m_stall < CNT_MOD - 1) m_stall++;
    m_vld = (ns == 1 && gv && !bp) ? 1 : 0;
    m_state = ns;
    m_hold = nh;
  endtask

  // Inputs are set before the edge; model and DUT are compared 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check("state", state, m_state);
    check("vld_en", vld_en, m_vld);
    check("mb_cnt", mb_cnt, m_mb);
    check("slice_cnt", slice_cnt, m_slice);
    check("stall_cycles", stall_cycles, m_stall);
  endtask

  task automatic drive(input logic r, input logic ce, input logic gv, input logic rf,
                       input logic mf, input logic mc, input logic mbe, input logic se);
    rst = r; clk_en = ce; getbits_valid = gv; rld_wr_almost_full = rf;
    mvec_wr_almost_full = mf; motcomp_busy = mc; macroblock_end = mbe; slice_end = se;
  endtask

  initial begin
    m_state = 0; m_hold = 0; m_vld = 0; m_mb = 0; m_slice = 0; m_stall = 0;
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    check("reset_state", state, 0);
    check("reset_vld_en", vld_en, 0);

    // Enter RUN, then pulse rld almost-full for one cycle.
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    cycle();
    check("idle_to_run_vld", vld_en, 1);
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    cycle();
    check("bp_stall_vld", vld_en, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (4) cycle();
    check("resume_vld", vld_en, 1);

    // Macroblock end with motion compensation busy for 5 cycles.
    drive(0, 1, 1, 0, 0, 1, 1, 0);
    cycle();
    drive(0, 1, 1, 0, 0, 1, 0, 0);
    repeat (4) cycle();
    check("mb_wait_state", state, 3);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    check("mb_wait_exit_mb_cnt", mb_cnt, 1);

    // Slice boundaries until slice_cnt wraps.
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    cycle();
    for (int s = 0; s < CNT_MOD; s++) begin
      for (int m = 0; m < 3; m++) begin
        drive(0, 1, 1, 0, 0, 0, 1, 0); cycle();
      end
      drive(0, 1, 1, 0, 0, 0, 1, 1); cycle();
      if (s == 0) begin
        check("first_slice_cnt", slice_cnt, 1);
        check("first_slice_mb_cnt", mb_cnt, 0);
      end
    end
    check("slice_wrap", slice_cnt, 0);

    // Long backpressure: stall counter saturates; clk_en=0 freezes.
    drive(0, 1, 1, 0, 1, 0, 0, 0);
    repeat (CNT_MOD + 5) cycle();
    check("stall_saturate", stall_cycles, CNT_MOD - 1);
    drive(0, 0, 1, 0, 0, 1, 1, 1);
    repeat (3) cycle();
    check("freeze_state", state, 2);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Reset during MB_WAIT.
    drive(0, 1, 1, 0, 0, 1, 1, 0); cycle();
    drive(1, 1, 1, 0, 0, 1, 0, 0); cycle();
    check("rst_mid_wait_state", state, 0);
    check("rst_mid_wait_stall", stall_cycles, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0); cycle();
    drive(0, 1, 0, 0, 0, 0, 0, 0); cycle();
    check("gv_drop_idle", state, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(299) == 0),
            ($urandom_range(99) < 90),
            ($urandom_range(99) < 85),
            ($urandom_range(99) < 10),
            ($urandom_range(99) < 8),
            ($urandom_range(99) < 40),
            ($urandom_range(99) < 15),
            ($urandom_range(99) < 5));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
